multicycle_control: RTL

Multi-cycle control FSM for the 16-bit simplified MIPS datapath. It replaces single-cycle combinational control and the free-running PC increment. It sequences each instruction through fetch, decode, execute, memory and write-back states over a shared instruction/data memory that has a ready handshake. It drives every datapath mux select and write enable, and it stops the machine on the halt word.

---
 rtl/multicycle_control.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle control FSM for the 16-bit MIPS datapath
// Optional feature macro: BRANCH_EN (beq/bne decode and the BRANCH state).
module multicycle_control #(
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] ir,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_control,
  output logic        halted,
  output logic        illegal_op,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB       = 4'd7,
    S_BRANCH   = 4'd8,
    S_HALT     = 4'd9
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_ADDI = 4'b0100;
  localparam logic [3:0] OP_LW   = 4'b0101;
  localparam logic [3:0] OP_SW   = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_BEQ  = 4'b1000;
  localparam logic [3:0] OP_BNE  = 4'b1001;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  state_t     state_q, state_d;
  logic [3:0] op;
  logic       is_rtype;
  logic [3:0] r_fn;

  assign op = ir[15:12];

  always_comb begin
    is_rtype = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_SLT);
    case (op)
      OP_SUB:  r_fn = ALU_SUB;
      OP_AND:  r_fn = ALU_AND;
      OP_OR:   r_fn = ALU_OR;
      OP_SLT:  r_fn = ALU_SLT;
      default: r_fn = ALU_ADD;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'd0;
    alu_control = 4'd0;
    halted      = 1'b0;
    illegal_op  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req     = 1'b1;
        alu_src_b   = 2'd1;
        alu_control = ALU_ADD;
        // IR and PC+2 are committed only on the cycle the read completes
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b   = 2'd3;
        alu_control = ALU_ADD;
        if (ir == HALT_WORD)  state_d = S_HALT;
        else if (is_rtype)    state_d = S_EXEC_R;
        else begin
          case (op)
            OP_ADDI:      state_d = S_EXEC_I;
            OP_LW, OP_SW: state_d = S_MEM_ADDR;
`ifdef BRANCH_EN
            OP_BEQ, OP_BNE: state_d = S_BRANCH;
`endif
            default: begin
              illegal_op = 1'b1;
              state_d    = S_FETCH;
            end
          endcase
        end
      end
      S_EXEC_R: begin
        alu_src_a   = 1'b1;
        alu_control = r_fn;
        state_d     = S_WB;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'd2;
        alu_control = ALU_ADD;
        if (state_q == S_EXEC_I) state_d = S_WB;
        else                     state_d = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        if (mem_ready) state_d = S_WB;
      end
      S_MEM_WR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = is_rtype;
        mem_to_reg = (op == OP_LW);
        state_d    = S_FETCH;
      end
`ifdef BRANCH_EN
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 1'b1;
        pc_write    = (op == OP_BEQ) ? zero : !zero;
        state_d     = S_FETCH;
      end
`endif
      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset abandons any access in flight and silences every strobe that cycle
    if (reset) begin
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      iord        = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 1'b0;
      reg_write   = 1'b0;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'd0;
      alu_control = 4'd0;
      halted      = 1'b0;
      illegal_op  = 1'b0;
    end
  end

  assign state = reset ? 4'd0 : state_q;

`ifndef BRANCH_EN
  logic unused_zero;
  assign unused_zero = zero;
`endif

endmodule
